ram_arbiter: RTL and testbench

- Shares the single SRAM driver (base/ext RAM, 21-bit address, bit 20 selects bank) between the CPU instruction-fetch port and the data-memory port.
- Accepts req/ack transactions from each requester and grants one at a time.
- Drives the driver's enable, read_enable and write_enable, and holds address and data stable for the whole access.
- Bounds each access with a timeout and reports a sticky error.

---
 rtl/ram_arbiter_if.sv | 37 +++
 rtl/ram_arbiter.sv | 152 +++++++++++++++
 tb/tb_ram_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Requester and SRAM-driver signal bundle for ram_arbiter.
// slave = arbiter side; master = requesters plus SRAM driver side.
interface ram_arbiter_if #(
    parameter int ADDR_WIDTH = 21,
    parameter int DATA_WIDTH = 32
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic                  if_ack;
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  d_ack;
    logic                  ram_enable;
    logic                  ram_read_enable;
    logic                  ram_write_enable;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  ram_done;
    logic                  timeout_err;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rdata, ram_done,
        output if_rdata, if_ack, d_rdata, d_ack, ram_enable, ram_read_enable,
               ram_write_enable, ram_addr, ram_wdata, timeout_err
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rdata, ram_done,
        input  if_rdata, if_ack, d_rdata, d_ack, ram_enable, ram_read_enable,
               ram_write_enable, ram_addr, ram_wdata, timeout_err
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter (instruction fetch, data) in front of one SRAM driver, with access timeout.
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is data-over-fetch priority.
module ram_arbiter #(
    parameter int ADDR_WIDTH     = 21,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst,
    ram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    state_t                r_state;
    logic                  r_owner;   // 0 = fetch, 1 = data; doubles as last-grant for round robin
    logic                  r_we;
    logic [7:0]            r_cnt;
    logic                  r_ram_enable;
    logic                  r_ram_read_enable;
    logic                  r_ram_write_enable;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic [DATA_WIDTH-1:0] r_ram_wdata;
    logic [DATA_WIDTH-1:0] r_if_rdata;
    logic [DATA_WIDTH-1:0] r_d_rdata;
    logic                  r_if_ack;
    logic                  r_d_ack;
    logic                  r_timeout_err;

    logic                  w_any_req;
    logic                  w_grant_data;
    logic [7:0]            w_cnt_next;
    logic                  w_timeout;
    logic [DATA_WIDTH-1:0] w_rd_value;

    assign w_any_req  = bus.if_req | bus.d_req;
    assign w_cnt_next = r_cnt + 8'd1;
    assign w_timeout  = (w_cnt_next == TIMEOUT_LIMIT) && !bus.ram_done;
    assign w_rd_value = bus.ram_done ? bus.ram_rdata : '0;

    // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_grant_data = 1'b0;
        if (bus.if_req && bus.d_req) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
            w_grant_data = ~r_owner;
`else
            w_grant_data = 1'b1;
`endif
        end else begin
            w_grant_data = bus.d_req;
        end
    end

    // NOTE: state and registered outputs use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state            <= S_IDLE;
            r_owner            <= 1'b0;
            r_we               <= 1'b0;
            r_cnt              <= '0;
            r_ram_enable       <= 1'b0;
            r_ram_read_enable  <= 1'b0;
            r_ram_write_enable <= 1'b0;
            r_ram_addr         <= '0;
            r_ram_wdata        <= '0;
            r_if_rdata         <= '0;
            r_d_rdata          <= '0;
            r_if_ack           <= 1'b0;
            r_d_ack            <= 1'b0;
            r_timeout_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state      <= S_ISSUE;
                        r_owner      <= w_grant_data;
                        r_ram_enable <= 1'b1;
                        if (w_grant_data) begin
                            r_ram_addr         <= bus.d_addr;
                            r_ram_wdata        <= bus.d_wdata;
                            r_we               <= bus.d_we;
                            r_ram_read_enable  <= ~bus.d_we;
                            r_ram_write_enable <= bus.d_we;
                        end else begin
                            r_ram_addr         <= bus.if_addr;
                            r_we               <= 1'b0;
                            r_ram_read_enable  <= 1'b1;
                            r_ram_write_enable <= 1'b0;
                        end
                    end
                end

                S_ISSUE: begin
                    r_state            <= S_WAIT;
                    r_ram_read_enable  <= 1'b0;
                    r_ram_write_enable <= 1'b0;
                end

                S_WAIT: begin
                    r_cnt <= w_cnt_next;
                    if (bus.ram_done || w_timeout) begin
                        r_state      <= S_RESP;
                        r_ram_enable <= 1'b0;
                        if (w_timeout) begin
                            r_timeout_err <= 1'b1;
                        end
                        // Timed-out reads return zero; writes never touch the read-data registers.
                        if (r_owner) begin
                            r_d_ack <= 1'b1;
                            if (!r_we) begin
                                r_d_rdata <= w_rd_value;
                            end
                        end else begin
                            r_if_ack   <= 1'b1;
                            r_if_rdata <= w_rd_value;
                        end
                    end
                end

                S_RESP: begin
                    r_state  <= S_IDLE;
                    r_if_ack <= 1'b0;
                    r_d_ack  <= 1'b0;
                    r_cnt    <= '0;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ram_enable       = r_ram_enable;
    assign bus.ram_read_enable  = r_ram_read_enable;
    assign bus.ram_write_enable = r_ram_write_enable;
    assign bus.ram_addr         = r_ram_addr;
    assign bus.ram_wdata        = r_ram_wdata;
    assign bus.if_rdata         = r_if_rdata;
    assign bus.if_ack           = r_if_ack;
    assign bus.d_rdata          = r_d_rdata;
    assign bus.d_ack            = r_d_ack;
    assign bus.timeout_err      = r_timeout_err;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed vector table, reset/stray sequences, and
// randomized transactions checked against a transaction-level model.
module tb_ram_arbiter;
    localparam int TC = 16;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        bit          if_req;
        bit          d_req;
        bit          d_we;
        logic [20:0] if_addr;
        logic [20:0] d_addr;
        logic [31:0] d_wdata;
        logic [31:0] ram_rdata;
        int          delay;   // cycles after ISSUE at which ram_done pulses; -1 = never
        bit          stray;   // extra ram_done pulses in IDLE and in ISSUE
    } stim_t;

    typedef struct {
        bit          owner;
        int          ack_k;   // cycles from ISSUE to the ack
        int          n_rd;
        int          n_wr;
        logic [20:0] addr;
        logic [31:0] wdata;
        logic [31:0] if_rdata;
        logic [31:0] d_rdata;
        bit          err;
    } result_t;

    typedef struct {
        stim_t   s;
        result_t e;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    bit          m_last;
    logic [31:0] m_if;
    logic [31:0] m_d;
    logic [31:0] m_wdata;
    bit          m_err;

    ram_arbiter_if #(.ADDR_WIDTH(21), .DATA_WIDTH(32)) bus ();

    ram_arbiter #(
        .ADDR_WIDTH    (21),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(TC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic stim_t mk(input bit ir, input bit dr, input bit we, input logic [20:0] ia,
                                 input logic [20:0] da, input logic [31:0] wd,
                                 input logic [31:0] rd, input int dly, input bit stray);
        stim_t s;
        s.if_req = ir; s.d_req = dr; s.d_we = we; s.if_addr = ia; s.d_addr = da;
        s.d_wdata = wd; s.ram_rdata = rd; s.delay = dly; s.stray = stray;
        return s;
    endfunction

    function automatic result_t ex(input bit own, input int k, input int nrd, input int nwr,
                                   input logic [20:0] a, input logic [31:0] wd,
                                   input logic [31:0] ifr, input logic [31:0] dr, input bit err);
        result_t e;
        e.owner = own; e.ack_k = k; e.n_rd = nrd; e.n_wr = nwr; e.addr = a;
        e.wdata = wd; e.if_rdata = ifr; e.d_rdata = dr; e.err = err;
        return e;
    endfunction

    // Transaction-level model: winner, latency and data follow directly from the arbitration rules.
    task automatic model(input stim_t s, output result_t e);
        bit          tmo;
        bit          is_rd;
        logic [31:0] ret;
        if (s.if_req && s.d_req) e.owner = RR ? !m_last : 1'b1;
        else                     e.owner = s.d_req;
        tmo     = (s.delay < 1) || (s.delay > TC);
        e.ack_k = tmo ? TC + 1 : s.delay + 1;
        is_rd   = !e.owner || !s.d_we;
        ret     = tmo ? 32'h0 : s.ram_rdata;
        e.n_rd  = int'(is_rd);
        e.n_wr  = int'(!is_rd);
        e.addr  = e.owner ? s.d_addr : s.if_addr;
        if (e.owner) m_wdata = s.d_wdata;
        e.wdata = m_wdata;
        if (!e.owner)  m_if = ret;
        else if (is_rd) m_d = ret;
        m_err  = m_err | tmo;
        m_last = e.owner;
        e.if_rdata = m_if;
        e.d_rdata  = m_d;
        e.err      = m_err;
    endtask

    // Plays both requesters and the SRAM driver for one transaction; starts and ends at an IDLE negedge.
    task automatic exec(input stim_t s, output result_t r, output int bad);
        bit seen;
        seen = 1'b0;
        bad  = 0;
        r.owner = 1'b0; r.ack_k = -1; r.n_rd = 0; r.n_wr = 0; r.addr = '0; r.wdata = '0;
        r.if_rdata = '0; r.d_rdata = '0; r.err = 1'b0;
        if (s.stray) begin
            bus.if_req   = 1'b0;
            bus.d_req    = 1'b0;
            bus.ram_done = 1'b1;
            @(negedge clk);
            bus.ram_done = 1'b0;
            if (bus.if_ack || bus.d_ack || bus.ram_enable) bad++;
        end
        bus.if_req    = s.if_req;
        bus.d_req     = s.d_req;
        bus.d_we      = s.d_we;
        bus.if_addr   = s.if_addr;
        bus.d_addr    = s.d_addr;
        bus.d_wdata   = s.d_wdata;
        bus.ram_rdata = s.ram_rdata;
        @(negedge clk);
        r.addr  = bus.ram_addr;
        r.wdata = bus.ram_wdata;
        for (int k = 0; k <= TC + 8; k++) begin
            if (bus.ram_read_enable)  r.n_rd++;
            if (bus.ram_write_enable) r.n_wr++;
            if (k != 0 && (bus.ram_read_enable || bus.ram_write_enable)) bad++;
            if (bus.ram_addr !== r.addr || bus.ram_wdata !== r.wdata) bad++;
            if (bus.if_ack && bus.d_ack) bad++;
            if (bus.if_ack || bus.d_ack) begin
                if (bus.ram_enable !== 1'b0) bad++;
                r.owner    = bus.d_ack;
                r.ack_k    = k;
                r.if_rdata = bus.if_rdata;
                r.d_rdata  = bus.d_rdata;
                r.err      = bus.timeout_err;
                if (bus.d_ack) bus.d_req = 1'b0;
                else           bus.if_req = 1'b0;
                seen = 1'b1;
                break;
            end
            if (bus.ram_enable !== 1'b1) bad++;
            if (k == 1) begin
                bus.if_addr = ~s.if_addr;
                bus.d_addr  = ~s.d_addr;
                bus.d_wdata = ~s.d_wdata;
                bus.d_we    = ~s.d_we;
            end
            bus.ram_done = (k == s.delay) || (s.stray && k == 0);
            @(negedge clk);
        end
        bus.ram_done = 1'b0;
        if (!seen) begin
            bus.if_req = 1'b0;
            bus.d_req  = 1'b0;
        end
        @(negedge clk);
        if (bus.if_ack || bus.d_ack || bus.ram_enable) bad++;
    endtask

    task automatic compare(input string tag, input result_t o, input result_t e, input int bad);
        check({tag, ".owner"},    64'(o.owner),  64'(e.owner));
        check({tag, ".ack_k"},    64'(o.ack_k),  64'(e.ack_k));
        check({tag, ".n_rd"},     64'(o.n_rd),   64'(e.n_rd));
        check({tag, ".n_wr"},     64'(o.n_wr),   64'(e.n_wr));
        check({tag, ".addr"},     64'(o.addr),   64'(e.addr));
        check({tag, ".wdata"},    64'(o.wdata),  64'(e.wdata));
        check({tag, ".if_rdata"}, 64'(o.if_rdata), 64'(e.if_rdata));
        check({tag, ".d_rdata"},  64'(o.d_rdata),  64'(e.d_rdata));
        check({tag, ".err"},      64'(o.err),    64'(e.err));
        check({tag, ".protocol"}, 64'(bad),      64'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".ram_enable"}, 64'(bus.ram_enable),       64'(0));
        check({tag, ".ram_rd_en"},  64'(bus.ram_read_enable),  64'(0));
        check({tag, ".ram_wr_en"},  64'(bus.ram_write_enable), 64'(0));
        check({tag, ".ram_addr"},   64'(bus.ram_addr),         64'(0));
        check({tag, ".ram_wdata"},  64'(bus.ram_wdata),        64'(0));
        check({tag, ".if_rdata"},   64'(bus.if_rdata),         64'(0));
        check({tag, ".d_rdata"},    64'(bus.d_rdata),          64'(0));
        check({tag, ".if_ack"},     64'(bus.if_ack),           64'(0));
        check({tag, ".d_ack"},      64'(bus.d_ack),            64'(0));
        check({tag, ".timeout_err"}, 64'(bus.timeout_err),     64'(0));
    endtask

    initial begin
        vec_t    vecs[13];
        result_t obs;
        result_t exp_r;
        stim_t   s;
        int      bad;
        int      n_ack;
        int      n_en;
        bit          p_if;
        bit          p_d;
        logic [20:0] pif_addr;
        logic [20:0] pd_addr;
        logic [31:0] pd_wdata;
        bit          pd_we;
        int          sel;

        checks   = 0;
        failures = 0;

        vecs[0]  = '{mk(1, 0, 0, 21'h000010, 21'h0, 32'h0, 32'h1234_5678, 3, 0),
                     ex(0, 4, 1, 0, 21'h000010, 32'h0, 32'h1234_5678, 32'h0, 0)};
        vecs[1]  = '{mk(0, 1, 1, 21'h0, 21'h100004, 32'hCAFE_BABE, 32'hDEAD_BEEF, 2, 0),
                     ex(1, 3, 0, 1, 21'h100004, 32'hCAFE_BABE, 32'h1234_5678, 32'h0, 0)};
        vecs[2]  = '{mk(0, 1, 0, 21'h0, 21'h000200, 32'h0000_1111, 32'hA5A5_0001, 1, 0),
                     ex(1, 2, 1, 0, 21'h000200, 32'h0000_1111, 32'h1234_5678, 32'hA5A5_0001, 0)};
        vecs[3]  = '{mk(1, 0, 0, 21'h1FFFFF, 21'h0, 32'h0, 32'h0BAD_F00D, TC, 0),
                     ex(0, TC + 1, 1, 0, 21'h1FFFFF, 32'h0000_1111, 32'h0BAD_F00D, 32'hA5A5_0001, 0)};
        vecs[4]  = '{mk(1, 0, 0, 21'h000020, 21'h0, 32'h0, 32'h5555_AAAA, 3, 1),
                     ex(0, 4, 1, 0, 21'h000020, 32'h0000_1111, 32'h5555_AAAA, 32'hA5A5_0001, 0)};
        vecs[5]  = '{mk(1, 1, 0, 21'h000040, 21'h100080, 32'h0000_2222, 32'hC000_0005, 2, 0),
                     ex(1, 3, 1, 0, 21'h100080, 32'h0000_2222, 32'h5555_AAAA, 32'hC000_0005, 0)};
`ifdef RAM_ARB_ROUND_ROBIN_EN
        vecs[6]  = '{mk(1, 1, 0, 21'h000040, 21'h100080, 32'h0000_2222, 32'hC000_0006, 2, 0),
                     ex(0, 3, 1, 0, 21'h000040, 32'h0000_2222, 32'hC000_0006, 32'hC000_0005, 0)};
        vecs[7]  = '{mk(1, 1, 0, 21'h000040, 21'h100080, 32'h0000_2222, 32'hC000_0007, 2, 0),
                     ex(1, 3, 1, 0, 21'h100080, 32'h0000_2222, 32'hC000_0006, 32'hC000_0007, 0)};
`else
        vecs[6]  = '{mk(1, 1, 0, 21'h000040, 21'h100080, 32'h0000_2222, 32'hC000_0006, 2, 0),
                     ex(1, 3, 1, 0, 21'h100080, 32'h0000_2222, 32'h5555_AAAA, 32'hC000_0006, 0)};
        vecs[7]  = '{mk(1, 1, 0, 21'h000040, 21'h100080, 32'h0000_2222, 32'hC000_0007, 2, 0),
                     ex(1, 3, 1, 0, 21'h100080, 32'h0000_2222, 32'h5555_AAAA, 32'hC000_0007, 0)};
`endif
        vecs[8]  = '{mk(1, 0, 0, 21'h000040, 21'h0, 32'h0, 32'hC000_0008, 2, 0),
                     ex(0, 3, 1, 0, 21'h000040, 32'h0000_2222, 32'hC000_0008, 32'hC000_0007, 0)};
        vecs[9]  = '{mk(0, 1, 1, 21'h0, 21'h100100, 32'h1212_1212, 32'h9999_9999, 4, 0),
                     ex(1, 5, 0, 1, 21'h100100, 32'h1212_1212, 32'hC000_0008, 32'hC000_0007, 0)};
        vecs[10] = '{mk(0, 1, 0, 21'h0, 21'h001000, 32'h0000_3333, 32'hFFFF_FFFF, -1, 0),
                     ex(1, TC + 1, 1, 0, 21'h001000, 32'h0000_3333, 32'hC000_0008, 32'h0, 1)};
        vecs[11] = '{mk(1, 0, 0, 21'h000050, 21'h0, 32'h0, 32'h7777_7777, TC + 1, 0),
                     ex(0, TC + 1, 1, 0, 21'h000050, 32'h0000_3333, 32'h0, 32'h0, 1)};
        vecs[12] = '{mk(1, 0, 0, 21'h000060, 21'h0, 32'h0, 32'h600D_600D, 1, 0),
                     ex(0, 2, 1, 0, 21'h000060, 32'h0000_3333, 32'h600D_600D, 32'h0, 1)};

        rst = 1'b1;
        bus.if_req = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0; bus.if_addr = '0;
        bus.d_addr = '0; bus.d_wdata = '0; bus.ram_rdata = '0; bus.ram_done = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("reset");

        for (int i = 0; i < 13; i++) begin
            exec(vecs[i].s, obs, bad);
            compare($sformatf("vec%0d", i), obs, vecs[i].e, bad);
        end

        // Reset while a fetch sits in WAIT: the access is abandoned without an ack.
        bus.if_req  = 1'b1;
        bus.d_req   = 1'b0;
        bus.if_addr = 21'h000070;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("rst_mid.enable_before", 64'(bus.ram_enable), 64'(1));
        rst        = 1'b1;
        bus.if_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("rst_mid");
        n_ack = 0;
        n_en  = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.if_ack || bus.d_ack) n_ack++;
            if (bus.ram_enable) n_en++;
        end
        check("rst_mid.no_ack", 64'(n_ack), 64'(0));
        check("rst_mid.idle", 64'(n_en), 64'(0));

        m_last = 1'b0; m_if = '0; m_d = '0; m_wdata = '0; m_err = 1'b0;
        s = mk(1, 0, 0, 21'h000070, 21'h0, 32'h0, 32'h0707_0707, 2, 0);
        model(s, exp_r);
        exec(s, obs, bad);
        compare("after_rst", obs, exp_r, bad);

        p_if = 1'b0; p_d = 1'b0;
        pif_addr = '0; pd_addr = '0; pd_wdata = '0; pd_we = 1'b0;
        for (int n = 0; n < 80; n++) begin
            if (!p_if && $urandom_range(0, 1) == 1) begin
                p_if = 1'b1; pif_addr = 21'($urandom);
            end
            if (!p_d && $urandom_range(0, 1) == 1) begin
                p_d = 1'b1; pd_addr = 21'($urandom); pd_wdata = $urandom; pd_we = 1'($urandom);
            end
            if (!p_if && !p_d) begin
                p_if = 1'b1; pif_addr = 21'($urandom);
            end
            sel = $urandom_range(0, 9);
            if (sel < 7)       s.delay = $urandom_range(1, 5);
            else if (sel == 7) s.delay = TC;
            else if (sel == 8) s.delay = TC + 1;
            else               s.delay = -1;
            s.if_req = p_if; s.d_req = p_d; s.d_we = pd_we; s.if_addr = pif_addr;
            s.d_addr = pd_addr; s.d_wdata = pd_wdata; s.ram_rdata = $urandom;
            s.stray  = ($urandom_range(0, 7) == 0) && !p_if && !p_d;
            model(s, exp_r);
            exec(s, obs, bad);
            compare($sformatf("rnd%0d", n), obs, exp_r, bad);
            if (exp_r.owner) p_d = 1'b0;
            else             p_if = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
